counter_updown_nbit: RTL and testbench

Parametrised synchronous up/down counter: the general-width successor of the team's 3-bit up/down counter, reusable by FSM and display blocks as a modulo-N or saturating counter. Adds count enable, synchronous parallel load, a programmable terminal value, wrap or saturate mode, a registered Gray-coded copy of the count, and one-cycle carry/borrow pulses for cascading.

---
 rtl/counter_updown_nbit.sv | 104 ++++++++++
 tb/tb_counter_updown_nbit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_updown_nbit.sv
// counter_updown_nbit: WIDTH-bit up/down counter with load, wrap/saturate
// mode, registered Gray copy and one-cycle carry/borrow pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   en         count enable
//   x          direction, 1 = up, 0 = down
//   load       synchronous parallel load (beats en)
//   load_val   load value, clamped to MAX_VAL
//   state      registered count
//   state_gray registered Gray code of state
//   carry      pulse after an up-wrap MAX_VAL -> 0
//   borrow     pulse after a down-wrap 0 -> MAX_VAL
//   at_max     state == MAX_VAL
//   at_min     state == 0
module counter_updown_nbit #(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_gray,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAXV =
    MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV =
    RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO =
    '0;

  logic [WIDTH-1:0] nxt;
  logic             nxt_c;
  logic             nxt_b;
  logic             up;
  logic             dn;

  assign up = !load && en && x;
  assign dn = !load && en && !x;

  assign at_max = (state == MAXV);
  assign at_min = (state == ZERO);

  // Wrap targets are explicit so a MAX_VAL below
  // 2**WIDTH-1 never leaks into the unused codes.
  always_comb begin
    nxt   = state;
    nxt_c = 1'b0;
    nxt_b = 1'b0;
    unique case (1'b1)
      load: begin
        nxt = (load_val > MAXV) ? MAXV : load_val;
      end
      up: begin
        if (state < MAXV) begin
          nxt = state + ONE;
        end else if (!SATURATE) begin
          nxt   = ZERO;
          nxt_c = 1'b1;
        end
      end
      dn: begin
        if (state > ZERO) begin
          nxt = state - ONE;
        end else if (!SATURATE) begin
          nxt   = MAXV;
          nxt_b = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Gray is taken from the next value so it
  // lands on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RSTV;
      state_gray <= RSTV ^ (RSTV >> 1);
      carry      <= 1'b0;
      borrow     <= 1'b0;
    end else begin
      state      <= nxt;
      state_gray <= nxt ^ (nxt >> 1);
      carry      <= nxt_c;
      borrow     <= nxt_b;
    end
  end

endmodule

// File: tb/tb_counter_updown_nbit.sv
// tb_counter_updown_nbit: directed checks of counter_updown_nbit
// in default, MAX_VAL=5 wrap and MAX_VAL=5 saturate builds.
module tb_counter_updown_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] sa, ga, sb, gb, sc, gc;
  logic       ca, ba, mxa, mna;
  logic       cb, bb, mxb, mnb;
  logic       cc, bc, mxc, mnc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  counter_updown_nbit u_a (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .load(load), .load_val(load_val),
    .state(sa), .state_gray(ga),
    .carry(ca), .borrow(ba),
    .at_max(mxa), .at_min(mna)
  );

  counter_updown_nbit #(.MAX_VAL(5)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .load(load), .load_val(load_val),
    .state(sb), .state_gray(gb),
    .carry(cb), .borrow(bb),
    .at_max(mxb), .at_min(mnb)
  );

  counter_updown_nbit #(.MAX_VAL(5), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .load(load), .load_val(load_val),
    .state(sc), .state_gray(gc),
    .carry(cc), .borrow(bc),
    .at_max(mxc), .at_min(mnc)
  );

  typedef struct {
    logic       r, e, d, l;
    logic [2:0] lv;
    logic [2:0] st, gr;
    logic       c, b;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(
    input logic r, e, d, l,
    input logic [2:0] lv, st, gr,
    input logic c, b
  );
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.l = l;
    v.lv = lv; v.st = st; v.gr = gr;
    v.c = c; v.b = b;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic r, e, d, l,
    input logic [2:0] v
  );
    @(negedge clk);
    rst = r; en = e; x = d;
    load = l; load_val = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst en x load lv | state gray carry borrow
    tbl[0]  = mk(0,1,1,0,0, 0,0,0,0);
    tbl[1]  = mk(1,1,1,0,0, 1,1,0,0);
    tbl[2]  = mk(1,1,1,0,0, 2,3,0,0);
    tbl[3]  = mk(1,1,1,0,0, 3,2,0,0);
    tbl[4]  = mk(1,1,1,0,0, 4,6,0,0);
    tbl[5]  = mk(1,1,1,0,0, 5,7,0,0);
    tbl[6]  = mk(1,1,1,0,0, 6,5,0,0);
    tbl[7]  = mk(1,1,1,0,0, 7,4,0,0);
    tbl[8]  = mk(1,1,1,0,0, 0,0,1,0);
    tbl[9]  = mk(1,1,1,0,0, 1,1,0,0);
    tbl[10] = mk(1,1,1,0,0, 2,3,0,0);
    tbl[11] = mk(1,1,0,0,0, 1,1,0,0);
    tbl[12] = mk(1,1,0,0,0, 0,0,0,0);
    tbl[13] = mk(1,1,0,0,0, 7,4,0,1);
    tbl[14] = mk(1,1,0,0,0, 6,5,0,0);
    tbl[15] = mk(1,1,0,0,0, 5,7,0,0);
    tbl[16] = mk(1,1,0,0,0, 4,6,0,0);
    tbl[17] = mk(1,1,0,0,0, 3,2,0,0);
    tbl[18] = mk(1,0,1,0,0, 3,2,0,0);
    tbl[19] = mk(1,0,0,0,0, 3,2,0,0);
    tbl[20] = mk(1,0,1,0,0, 3,2,0,0);
    tbl[21] = mk(0,1,1,1,6, 0,0,0,0);
    tbl[22] = mk(1,1,1,0,0, 1,1,0,0);
    tbl[23] = mk(1,1,1,0,0, 2,3,0,0);
    tbl[24] = mk(1,1,0,1,6, 6,5,0,0);
    tbl[25] = mk(1,1,1,0,0, 7,4,0,0);

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d,
           tbl[i].l, tbl[i].lv);
      chk($sformatf("vec%0d", i),
          {4'd0, sa, ga, ca, ba, mxa, mna},
          {4'd0, tbl[i].st, tbl[i].gr,
           tbl[i].c, tbl[i].b,
           tbl[i].st == 3'd7,
           tbl[i].st == 3'd0});
    end

    // load beats en and clamps to MAX_VAL=5
    step(0, 1, 1, 0, 0);
    chk("rst_b", {12'd0, sb, cb}, 16'd0);
    chk("rst_c", {12'd0, sc, cc}, 16'd0);
    step(1, 1, 1, 1, 7);
    chk("ld_b", {8'd0, sb, gb, cb, mxb},
        {8'd0, 3'd5, 3'd7, 1'b0, 1'b1});
    chk("ld_c", {12'd0, sc, mxc},
        {12'd0, 3'd5, 1'b1});
    step(1, 1, 1, 0, 0);
    chk("wrap_b", {12'd0, sb, cb},
        {12'd0, 3'd0, 1'b1});
    chk("sat_hold", {12'd0, sc, cc},
        {12'd0, 3'd5, 1'b0});
    step(1, 0, 1, 0, 0);
    chk("pulse_b", {15'd0, cb}, 16'd0);

    // saturate run from 0
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 0);
      chk($sformatf("sat_up%0d", i),
          {11'd0, sc, cc, bc},
          {11'd0, (i < 5) ? 3'(i + 1) : 3'd5,
           2'b00});
    end
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("sat_dn%0d", i),
          {11'd0, sc, cc, bc},
          {11'd0, (i < 5) ? 3'(4 - i) : 3'd0,
           2'b00});
    end
    chk("sat_min", {15'd0, mnc}, 16'd1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
